// File: rtl/ula_op_sequencer.sv
// Command/response front end for sequential_basic_ula: one op in flight, with timeout and
// illegal-op detection. Define ULA_OP_SEQUENCER_STATS_EN to add saturating response counters.
module ula_op_sequencer #(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned RES_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [4:0]        i_cmd_op,
    input  logic [DATA_W-1:0] i_cmd_a,
    input  logic [DATA_W-1:0] i_cmd_b,
    output logic [4:0]        o_alu_op,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    input  logic              i_alu_valid,
    input  logic [RES_W-1:0]  i_alu_result,
    input  logic              i_alu_carryout,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [4:0]        o_rsp_op,
    output logic [RES_W-1:0]  o_rsp_result,
    output logic              o_rsp_carryout,
    output logic [1:0]        o_rsp_status
`ifdef ULA_OP_SEQUENCER_STATS_EN
    ,
    output logic [15:0]       o_stat_ok,
    output logic [7:0]        o_stat_timeout,
    output logic [7:0]        o_stat_illegal
`endif
);

    // Op codes shared with sequential_basic_ula.
    localparam logic [4:0] OP_ADD = 5'h00;
    localparam logic [4:0] OP_SUB = 5'h01;
    localparam logic [4:0] OP_MUL = 5'h02;
    localparam logic [4:0] OP_DIV = 5'h03;
    localparam logic [4:0] OP_AND = 5'h04;
    localparam logic [4:0] OP_OR  = 5'h05;
    localparam logic [4:0] OP_XOR = 5'h06;
    localparam logic [4:0] OP_REV = 5'h07;

    localparam logic [1:0] StatusOk      = 2'b00;
    localparam logic [1:0] StatusTimeout = 2'b01;
    localparam logic [1:0] StatusIllegal = 2'b10;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          wait_cnt_q, wait_cnt_d;
    logic [4:0]          alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [4:0]          rsp_op_q, rsp_op_d;
    logic [RES_W-1:0]    rsp_result_q, rsp_result_d;
    logic                rsp_carry_q, rsp_carry_d;
    logic [1:0]          rsp_status_q, rsp_status_d;

    function automatic logic op_is_legal(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV,
            OP_AND, OP_OR, OP_XOR, OP_REV: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_op_d     = rsp_op_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_status_d = rsp_status_q;

        unique case (state_q)
            StIdle: begin
                if (i_cmd_valid) begin
                    rsp_op_d = i_cmd_op;
                    if (op_is_legal(i_cmd_op)) begin
                        // The ALU input registers double as the registered command.
                        alu_op_d = i_cmd_op;
                        alu_a_d  = i_cmd_a;
                        alu_b_d  = i_cmd_b;
                        state_d  = StIssue;
                    end else begin
                        rsp_result_d = '0;
                        rsp_carry_d  = 1'b0;
                        rsp_status_d = StatusIllegal;
                        state_d      = StResp;
                    end
                end
            end
            StIssue: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                // Valid is checked first so it wins over a coincident timeout.
                if (i_alu_valid) begin
                    rsp_result_d = i_alu_result;
                    rsp_carry_d  = i_alu_carryout;
                    rsp_status_d = StatusOk;
                    state_d      = StResp;
                end else if (wait_cnt_q == TimeoutLast) begin
                    rsp_result_d = '0;
                    rsp_carry_d  = 1'b0;
                    rsp_status_d = StatusTimeout;
                    state_d      = StResp;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StResp: begin
                if (i_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            wait_cnt_q   <= '0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_status_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_op_q     <= rsp_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    // Gated by rst so ready stays low for the whole reset window.
    assign o_cmd_ready    = (state_q == StIdle) && !rst;
    assign o_rsp_valid    = (state_q == StResp);
    assign o_alu_op       = alu_op_q;
    assign o_alu_a        = alu_a_q;
    assign o_alu_b        = alu_b_q;
    assign o_rsp_op       = rsp_op_q;
    assign o_rsp_result   = rsp_result_q;
    assign o_rsp_carryout = rsp_carry_q;
    assign o_rsp_status   = rsp_status_q;

`ifdef ULA_OP_SEQUENCER_STATS_EN
    logic        rsp_fire;
    logic [15:0] stat_ok_q;
    logic [7:0]  stat_timeout_q;
    logic [7:0]  stat_illegal_q;

    assign rsp_fire = o_rsp_valid && i_rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ok_q      <= '0;
            stat_timeout_q <= '0;
            stat_illegal_q <= '0;
        end else if (rsp_fire) begin
            unique case (rsp_status_q)
                StatusOk: begin
                    if (stat_ok_q != '1) stat_ok_q <= stat_ok_q + 16'd1;
                end
                StatusTimeout: begin
                    if (stat_timeout_q != '1) stat_timeout_q <= stat_timeout_q + 8'd1;
                end
                StatusIllegal: begin
                    if (stat_illegal_q != '1) stat_illegal_q <= stat_illegal_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_stat_ok      = stat_ok_q;
    assign o_stat_timeout = stat_timeout_q;
    assign o_stat_illegal = stat_illegal_q;
`endif

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Scoreboard bench for ula_op_sequencer: a driver issues commands and plays the ALU, a monitor
// checks every presented response against expectations computed from a behavioural ALU model.
module tb_ula_op_sequencer;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned RES_W  = 32;
    localparam int unsigned TMO    = 16;

    localparam logic [4:0] OP_ADD = 5'h00;
    localparam logic [4:0] OP_SUB = 5'h01;
    localparam logic [4:0] OP_MUL = 5'h02;
    localparam logic [4:0] OP_DIV = 5'h03;
    localparam logic [4:0] OP_AND = 5'h04;
    localparam logic [4:0] OP_OR  = 5'h05;
    localparam logic [4:0] OP_XOR = 5'h06;
    localparam logic [4:0] OP_REV = 5'h07;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_cmd_valid = 1'b0;
    logic              o_cmd_ready;
    logic [4:0]        i_cmd_op = '0;
    logic [DATA_W-1:0] i_cmd_a = '0;
    logic [DATA_W-1:0] i_cmd_b = '0;
    logic [4:0]        o_alu_op;
    logic [DATA_W-1:0] o_alu_a;
    logic [DATA_W-1:0] o_alu_b;
    logic              i_alu_valid = 1'b0;
    logic [RES_W-1:0]  i_alu_result = '0;
    logic              i_alu_carryout = 1'b0;
    logic              o_rsp_valid;
    logic              i_rsp_ready = 1'b0;
    logic [4:0]        o_rsp_op;
    logic [RES_W-1:0]  o_rsp_result;
    logic              o_rsp_carryout;
    logic [1:0]        o_rsp_status;
`ifdef ULA_OP_SEQUENCER_STATS_EN
    logic [15:0]       o_stat_ok;
    logic [7:0]        o_stat_timeout;
    logic [7:0]        o_stat_illegal;
`endif

    ula_op_sequencer #(
        .DATA_W         (DATA_W),
        .RES_W          (RES_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_op       (i_cmd_op),
        .i_cmd_a        (i_cmd_a),
        .i_cmd_b        (i_cmd_b),
        .o_alu_op       (o_alu_op),
        .o_alu_a        (o_alu_a),
        .o_alu_b        (o_alu_b),
        .i_alu_valid    (i_alu_valid),
        .i_alu_result   (i_alu_result),
        .i_alu_carryout (i_alu_carryout),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_op       (o_rsp_op),
        .o_rsp_result   (o_rsp_result),
        .o_rsp_carryout (o_rsp_carryout),
        .o_rsp_status   (o_rsp_status)
`ifdef ULA_OP_SEQUENCER_STATS_EN
        ,
        .o_stat_ok      (o_stat_ok),
        .o_stat_timeout (o_stat_timeout),
        .o_stat_illegal (o_stat_illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] res;
        logic        car;
        logic [1:0]  st;
        int          lat;   // edges from accept to first valid; -1 = unchecked
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rdy_mode = 1;     // 0 random, 1 always ready, 2 stalled
    bit   prev_valid = 1'b0;
    int   n_ok = 0, n_tmo = 0, n_ill = 0;
    logic [4:0]  last_op = '0;
    logic [15:0] last_a = '0, last_b = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic void alu_model(input logic [4:0] op, input logic [15:0] a,
                                      input logic [15:0] b, output logic [31:0] r,
                                      output logic c);
        logic [16:0] s;
        r = '0;
        c = 1'b0;
        case (op)
            OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = {16'h0, s[15:0]}; c = s[16]; end
            OP_SUB: begin s = {1'b0, a} - {1'b0, b}; r = {16'h0, s[15:0]}; c = s[16]; end
            OP_MUL: r = {16'h0, a} * {16'h0, b};
            OP_DIV: r = (b == 0) ? 32'hFFFF_FFFF : {16'h0, a / b};
            OP_AND: r = {16'h0, a & b};
            OP_OR:  r = {16'h0, a | b};
            OP_XOR: r = {16'h0, a ^ b};
            OP_REV: for (int i = 0; i < 16; i++) r[i] = a[15 - i];
            default: ;
        endcase
    endfunction

    // Response-ready driver.
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       i_rsp_ready = ($urandom_range(0, 3) != 0);
            1:       i_rsp_ready = 1'b1;
            default: i_rsp_ready = 1'b0;
        endcase
    end

    // Monitor: every presented response must match the queue head, every cycle until handshake.
    always @(negedge clk) begin
        if (!rst && o_rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: op 0x%0h status %0d with empty scoreboard",
                         o_rsp_op, o_rsp_status);
            end else begin
                mon_e = exp_q[0];
                chk("rsp_op", 64'(o_rsp_op), 64'(mon_e.op));
                chk("rsp_result", 64'(o_rsp_result), 64'(mon_e.res));
                chk("rsp_carry", 64'(o_rsp_carryout), 64'(mon_e.car));
                chk("rsp_status", 64'(o_rsp_status), 64'(mon_e.st));
                chk("cmd_ready_in_resp", 64'(o_cmd_ready), 64'd0);
                if (!prev_valid && mon_e.lat >= 0)
                    chk("rsp_latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                if (i_rsp_ready) begin
                    void'(exp_q.pop_front());
                    case (mon_e.st)
                        2'b00:   if (n_ok < 65535) n_ok++;
                        2'b01:   if (n_tmo < 255) n_tmo++;
                        default: if (n_ill < 255) n_ill++;
                    endcase
                end
            end
        end
        prev_valid = o_rsp_valid;
    end

    // Issue one command and play the ALU. n = WAIT cycle carrying i_alu_valid (0 = never).
    task automatic send(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int n, input logic [31:0] res, input logic car, input bit do_wait);
        bit   acc = 1'b0;
        bit   rdy;
        bit   legal;
        bit   ok;
        int   w;
        exp_t e;
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b1;
        i_cmd_op = op;
        i_cmd_a = a;
        i_cmd_b = b;
        for (int k = 0; k < 400 && !acc; k++) begin
            @(negedge clk);
            rdy = o_cmd_ready;
            @(posedge clk);
            if (rdy) acc = 1'b1;
        end
        #1;
        i_cmd_valid = 1'b0;
        i_cmd_op = 5'($urandom);
        i_cmd_a = 16'($urandom);
        i_cmd_b = 16'($urandom);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept: o_cmd_ready never seen within 400 cycles");
            return;
        end
        legal = (op < 5'd8);
        ok = legal && n >= 1 && n <= int'(TMO);
        w = ok ? n : int'(TMO);
        if (legal) begin
            last_op = op;
            last_a = a;
            last_b = b;
        end
        if (!do_wait) return;
        e.op = op;
        e.res = ok ? res : 32'h0;
        e.car = ok ? car : 1'b0;
        e.st = !legal ? 2'b10 : (ok ? 2'b00 : 2'b01);
        // One ISSUE edge plus one edge per WAIT cycle.
        e.lat = legal ? w + 1 : -1;
        e.acc = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        chk("alu_op_held", 64'(o_alu_op), 64'(last_op));
        chk("alu_a_held", 64'(o_alu_a), 64'(last_a));
        chk("alu_b_held", 64'(o_alu_b), 64'(last_b));
        if (!legal) return;
        for (int k = 1; k <= w; k++) begin
            @(posedge clk);
            #1;
            if (ok && k == n) begin
                i_alu_valid = 1'b1;
                i_alu_result = res;
                i_alu_carryout = car;
            end else begin
                i_alu_valid = 1'b0;
                i_alu_result = $urandom;
                i_alu_carryout = 1'($urandom);
            end
            @(negedge clk);
            chk("alu_op_wait", 64'(o_alu_op), 64'(op));
            chk("alu_a_wait", 64'(o_alu_a), 64'(a));
            chk("alu_b_wait", 64'(o_alu_b), 64'(b));
        end
        @(posedge clk);
        #1;
        i_alu_valid = 1'b0;
    endtask

    task automatic send_m(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int n);
        logic [31:0] r;
        logic        c;
        alu_model(op, a, b, r, c);
        send(op, a, b, n, r, c, 1'b1);
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d responses still pending", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_op = '0;
        last_a = '0;
        last_b = '0;
        n_ok = 0;
        n_tmo = 0;
        n_ill = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("reset_cmd_ready", 64'(o_cmd_ready), 64'd1);
        chk("reset_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("reset_alu_op", 64'(o_alu_op), 64'd0);
        chk("reset_rsp_result", 64'(o_rsp_result), 64'd0);
        chk("reset_rsp_status", 64'(o_rsp_status), 64'd0);

        // Directed scenarios.
        send_m(OP_ADD, 16'h0FFF, 16'h0001, 1);
        @(negedge clk);
        rdy_mode = 2;
        send_m(OP_MUL, 16'h0004, 16'h0002, 1);
        repeat (5) @(negedge clk);
        rdy_mode = 1;
        send_m(OP_XOR, 16'h00FF, 16'h0005, 0);
        send(5'h1F, 16'h1234, 16'h5678, 0, 32'h0, 1'b0, 1'b1);
        send_m(OP_SUB, 16'h0000, 16'h0001, int'(TMO));      // valid on the timeout cycle
        send_m(OP_ADD, 16'hFFFF, 16'h0001, int'(TMO) + 1);  // valid one cycle too late
        send(OP_REV, 16'h8001, 16'h0, 3, 32'hDEAD_BEEF, 1'b1, 1'b1);  // pass-through, no masking

        // Reset during WAIT drops the command.
        drain();
        send(OP_SUB, 16'h0004, 16'h0001, 0, 32'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("midrst_cmd_ready", 64'(o_cmd_ready), 64'd1);
        chk("midrst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("midrst_alu_op", 64'(o_alu_op), 64'd0);
        chk("midrst_alu_a", 64'(o_alu_a), 64'd0);
        chk("midrst_alu_b", 64'(o_alu_b), 64'd0);
        chk("midrst_rsp_op", 64'(o_rsp_op), 64'd0);
        send_m(OP_OR, 16'h0005, 16'h0002, 2);

        // Randomized traffic with random response backpressure.
        @(negedge clk);
        rdy_mode = 0;
        for (int t = 0; t < 40; t++) begin
            logic [4:0]  op;
            int          sel;
            int          n;
            sel = $urandom_range(0, 9);
            op = (sel < 8) ? 5'(sel) : 5'($urandom_range(8, 31));
            n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            if ($urandom_range(0, 1) == 0)
                send_m(op, 16'($urandom), 16'($urandom), n);
            else
                send(op, 16'($urandom), 16'($urandom), n, $urandom, 1'($urandom), 1'b1);
        end
        drain();
        @(negedge clk);
        rdy_mode = 1;

        // Fresh reset, then one OK, one TIMEOUT and one ILLEGAL response.
        @(posedge clk);
        #1;
        do_reset();
        send_m(OP_ADD, 16'h0FFF, 16'h0001, 1);
        send_m(OP_XOR, 16'h00FF, 16'h0005, 0);
        send(5'h1F, 16'h0, 16'h0, 0, 32'h0, 1'b0, 1'b1);
        drain();
        @(negedge clk);
`ifdef ULA_OP_SEQUENCER_STATS_EN
        chk("stat_ok", 64'(o_stat_ok), 64'(n_ok));
        chk("stat_timeout", 64'(o_stat_timeout), 64'(n_tmo));
        chk("stat_illegal", 64'(o_stat_illegal), 64'(n_ill));
        chk("stat_ok_one", 64'(o_stat_ok), 64'd1);
`endif
        chk("idle_cmd_ready", 64'(o_cmd_ready), 64'd1);
        chk("idle_rsp_valid", 64'(o_rsp_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
